// File: rtl/frame_rate_meas_mbi.sv
// frame_rate_meas_mbi
//   Measures the incoming vsync frame period in prescaled ticks (clk / DIV) and
//   checks that it stays stable from frame to frame. It supplies the output
//   timing generator with:
//     - the frame period;
//     - a 50/60 Hz decision;
//     - a frame toggle.
//   When vsync is absent it free-runs at FREERUN_CNT ticks, so the display
//   timing keeps going.
//
// Ports
//   clk        in   system clock (25 MHz nominal)
//   rst_n      in   asynchronous reset, active-low
//   vsync      in   frame start, asynchronous to clk, rising edge = new frame
//   fr_rate    out  frame period in ticks (FREERUN_CNT when not locked yet)
//   f50hz      out  1: 50 Hz source, 0: 60 Hz source
//   frame_alt  out  toggles once per frame event
//   sig_lock   out  stable measurement in use
//   no_sig     out  vsync absent, free-running
//
// Build option
//   FRAME_AVG_EN  when defined, fr_rate in lock is the mean of the last four
//                 qualified periods; otherwise it is the raw period.
module frame_rate_meas_mbi #(
    parameter int unsigned DIV         = 20,
    parameter int unsigned TOL         = 16,
    parameter int unsigned STABLE_N    = 3,
    parameter int unsigned MIN_P       = 16000,
    parameter int unsigned MAX_P       = 30000,
    parameter int unsigned F50_TH      = 22917,
    parameter int unsigned TIMEOUT     = 40000,
    parameter int unsigned FREERUN_CNT = 20833
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    output logic [15:0] fr_rate,
    output logic        f50hz,
    output logic        frame_alt,
    output logic        sig_lock,
    output logic        no_sig
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE_N + 1);

    typedef enum logic [1:0] {StNoSig, StAcq, StLock} state_e;

    state_e          state_q, state_d;
    logic            vs_meta_q, vs_sync_q, vs_dly_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     pc_q, pc_d;
    logic [15:0]     prev_q, prev_d;
    logic            have_prev_q, have_prev_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic [15:0]     fr_rate_q, fr_rate_d;
    logic            f50hz_q, f50hz_d;
    logic            frame_alt_q, frame_alt_d;

    logic            vs_rise;
    logic            tick;
    logic [15:0]     meas;
    logic            valid;
    logic            match;
    logic            qual;
    logic signed [16:0] diff;
    logic [16:0]     diff_mag;
    logic [15:0]     pc_inc;
    logic            timeout_hit;
    logic [15:0]     upd_rate;

    assign vs_rise  = vs_sync_q & ~vs_dly_q;
    assign tick     = (presc_q == PW'(DIV - 1));
    assign meas     = pc_q;
    assign valid    = (meas >= 16'(MIN_P)) && (meas <= 16'(MAX_P));
    assign diff     = signed'({1'b0, meas}) - signed'({1'b0, prev_q});
    assign diff_mag = diff[16] ? 17'(-diff) : 17'(diff);
    assign match    = have_prev_q && (diff_mag <= 17'(TOL));
    assign qual     = valid && match;
    assign pc_inc   = (pc_q == 16'hFFFF) ? pc_q : pc_q + 16'd1;
    // pc is about to reach TIMEOUT on this tick
    assign timeout_hit = ({1'b0, pc_q} + 17'd1) >= 17'(TIMEOUT);

`ifdef FRAME_AVG_EN
    logic [15:0] hist_q [3];
    logic [15:0] hist_d [3];
    logic [17:0] avg_sum;

    // Current period plus the three previous qualified ones
    assign avg_sum  = 18'(meas) + 18'(hist_q[0]) + 18'(hist_q[1]) + 18'(hist_q[2]);
    assign upd_rate = avg_sum[17:2];
`else
    assign upd_rate = meas;
`endif

    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + PW'(1);
        pc_d        = pc_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        stab_d      = stab_q;
        fr_rate_d   = fr_rate_q;
        f50hz_d     = f50hz_q;
        frame_alt_d = frame_alt_q;
`ifdef FRAME_AVG_EN
        for (int i = 0; i < 3; i++) hist_d[i] = hist_q[i];
`endif

        if (vs_rise) begin
            // A tick in the same cycle is dropped; the edge wins over
            // timeout and free-run wrap.
            pc_d        = '0;
            frame_alt_d = ~frame_alt_q;
            unique case (state_q)
                StNoSig: begin
                    state_d     = StAcq;
                    have_prev_d = 1'b0;
                    stab_d      = '0;
                end
                StAcq: begin
                    prev_d      = meas;
                    have_prev_d = valid;
                    if (qual) begin
                        if (stab_q == SW'(STABLE_N - 1)) begin
                            state_d   = StLock;
                            stab_d    = '0;
                            fr_rate_d = meas;
                            f50hz_d   = (meas > 16'(F50_TH));
`ifdef FRAME_AVG_EN
                            for (int i = 0; i < 3; i++) hist_d[i] = meas;
`endif
                        end else begin
                            stab_d = stab_q + SW'(1);
                        end
                    end else begin
                        stab_d = '0;
                    end
                end
                StLock: begin
                    prev_d      = meas;
                    have_prev_d = valid;
                    if (qual) begin
                        fr_rate_d = upd_rate;
                        f50hz_d   = (upd_rate > 16'(F50_TH));
`ifdef FRAME_AVG_EN
                        hist_d[0] = meas;
                        hist_d[1] = hist_q[0];
                        hist_d[2] = hist_q[1];
`endif
                    end else begin
                        state_d = StAcq;
                        stab_d  = '0;
                    end
                end
                default: state_d = StNoSig;
            endcase
        end else if (tick) begin
            if (state_q == StNoSig) begin
                // Free-run wrap stands in for a frame edge
                if (pc_q >= 16'(FREERUN_CNT - 1)) begin
                    pc_d        = '0;
                    frame_alt_d = ~frame_alt_q;
                end else begin
                    pc_d = pc_inc;
                end
            end else if (timeout_hit) begin
                state_d   = StNoSig;
                pc_d      = '0;
                stab_d    = '0;
                fr_rate_d = 16'(FREERUN_CNT);
                f50hz_d   = 1'b0;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StNoSig;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_dly_q    <= 1'b0;
            presc_q     <= '0;
            pc_q        <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            stab_q      <= '0;
            fr_rate_q   <= 16'(FREERUN_CNT);
            f50hz_q     <= 1'b0;
            frame_alt_q <= 1'b0;
`ifdef FRAME_AVG_EN
            for (int i = 0; i < 3; i++) hist_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vs_meta_q   <= vsync;
            vs_sync_q   <= vs_meta_q;
            vs_dly_q    <= vs_sync_q;
            presc_q     <= presc_d;
            pc_q        <= pc_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            stab_q      <= stab_d;
            fr_rate_q   <= fr_rate_d;
            f50hz_q     <= f50hz_d;
            frame_alt_q <= frame_alt_d;
`ifdef FRAME_AVG_EN
            for (int i = 0; i < 3; i++) hist_q[i] <= hist_d[i];
`endif
        end
    end

    assign fr_rate   = fr_rate_q;
    assign f50hz     = f50hz_q;
    assign frame_alt = frame_alt_q;
    assign sig_lock  = (state_q == StLock);
    assign no_sig    = (state_q == StNoSig);

endmodule

// File: tb/tb_frame_rate_meas_mbi.sv
// Bench for frame_rate_meas_mbi with time-scaled parameters (DIV=4, periods
// about 1/100 of nominal) so the run stays short. Expected outputs come from
// a per-frame model of the lock rules kept below. All vsync edges are spaced
// in whole ticks and placed mid-tick, so each measured period is exactly
// gap/DIV.
module tb_frame_rate_meas_mbi;

    localparam int unsigned DIV         = 4;
    localparam int unsigned TOL         = 4;
    localparam int unsigned STABLE_N    = 3;
    localparam int unsigned MIN_P       = 160;
    localparam int unsigned MAX_P       = 300;
    localparam int unsigned F50_TH      = 229;
    localparam int unsigned TIMEOUT     = 400;
    localparam int unsigned FREERUN_CNT = 208;

    localparam int P60   = 208 * DIV;
    localparam int P50   = 250 * DIV;
    localparam int T_CLK = TIMEOUT * DIV;
    localparam int F_CLK = FREERUN_CNT * DIV;
    localparam int FIRST_PHASE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] fr_rate;
    logic        f50hz, frame_alt, sig_lock, no_sig;

    int total = 0;
    int bad = 0;
    int cyc;
    int last_edge;

    // Frame-level model state: 0 no signal, 1 acquiring, 2 locked
    int m_state, m_prev, m_stab, m_fr;
    bit m_have, m_f50, m_alt;

    frame_rate_meas_mbi #(
        .DIV(DIV), .TOL(TOL), .STABLE_N(STABLE_N), .MIN_P(MIN_P), .MAX_P(MAX_P),
        .F50_TH(F50_TH), .TIMEOUT(TIMEOUT), .FREERUN_CNT(FREERUN_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (vsync),
        .fr_rate  (fr_rate),
        .f50hz    (f50hz),
        .frame_alt(frame_alt),
        .sig_lock (sig_lock),
        .no_sig   (no_sig)
    );

    always #20 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [19:0] obs_vec();
        return {fr_rate, f50hz, frame_alt, sig_lock, no_sig};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {16'(m_fr), m_f50, m_alt, (m_state == 2), (m_state == 0)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_stab = 0; m_fr = FREERUN_CNT;
        m_have = 0; m_f50 = 0; m_alt = 0;
    endtask

    task automatic model_edge(input int meas);
        bit ok;
        int d;
        m_alt = ~m_alt;
        if (m_state == 0) begin
            m_state = 1; m_have = 0; m_stab = 0;
            return;
        end
        d  = meas - m_prev;
        if (d < 0) d = -d;
        ok = (meas >= MIN_P) && (meas <= MAX_P) && m_have && (d <= TOL);
        if (m_state == 1) begin
            if (ok) begin
                m_stab++;
                if (m_stab == STABLE_N) begin
                    m_state = 2; m_stab = 0; m_fr = meas; m_f50 = (meas > F50_TH);
                end
            end else begin
                m_stab = 0;
            end
        end else begin
            if (ok) begin
                m_fr = meas; m_f50 = (meas > F50_TH);
            end else begin
                m_state = 1; m_stab = 0;
            end
        end
        m_prev = meas;
        m_have = (meas >= MIN_P) && (meas <= MAX_P);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drop vsync from the previous frame, raise it gap clk after the last
    // rising edge, update the model, then wait for the outputs to settle.
    task automatic do_edge(input int gap);
        wait_until(last_edge + 20);
        vsync = 1'b0;
        wait_until(last_edge + gap);
        vsync = 1'b1;
        last_edge = cyc;
        model_edge(gap / DIV);
        repeat (8) @(negedge clk);
    endtask

    task automatic start_after_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        last_edge = FIRST_PHASE - P60;
    endtask

    task automatic test_reset();
        vsync = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
        end
        start_after_reset();
        repeat (30) @(negedge clk);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_lock_60();
        for (int i = 0; i < 6; i++) begin
            do_edge(P60);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL lock60 edge %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_50hz_switch();
        for (int i = 0; i < 11; i++) begin
            do_edge(i < 6 ? P50 : P60);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL 50hz_switch edge %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_jitter();
        int gaps [7];
        gaps = '{212 * DIV, 208 * DIV, 213 * DIV, P60, P60, P60, P60};
        for (int i = 0; i < 7; i++) begin
            do_edge(gaps[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL jitter edge %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int base, j;
        for (int r = 0; r < 2; r++) begin
            base = int'($urandom_range(295, 165));
            for (int i = 0; i < 6; i++) begin
                j = int'($urandom_range(10, 0)) - 5;
                do_edge((base + j) * DIV);
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL random r%0d edge %0d meas %0d: got %h want %h",
                             r, i, base + j, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_range();
        int gaps [3];
        gaps = '{120 * DIV, MAX_P * DIV, (MAX_P + 1) * DIV};
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 5; i++) begin
                do_edge(gaps[g]);
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL range gap %0d edge %0d: got %h want %h",
                             gaps[g], i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_timeout();
        int l;
        for (int i = 0; i < 5; i++) begin
            do_edge(P60);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL timeout_prelock edge %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        l = last_edge;
        wait_until(l + 20);
        vsync = 1'b0;
        wait_until(l + T_CLK - 12);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL timeout_early: got %h want %h", obs_vec(), exp_vec());
        end
        wait_until(l + T_CLK + 12);
        m_state = 0; m_stab = 0; m_fr = FREERUN_CNT; m_f50 = 0;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL timeout_nosig: got %h want %h", obs_vec(), exp_vec());
        end
        wait_until(l + T_CLK + F_CLK - 12);
        total++;
        if (frame_alt !== m_alt) begin
            bad++;
            $display("FAIL freerun_before_wrap: got %b want %b", frame_alt, m_alt);
        end
        for (int k = 1; k <= 2; k++) begin
            wait_until(l + T_CLK + k * F_CLK + 12);
            m_alt = ~m_alt;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL freerun_wrap %0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        do_edge(T_CLK + 2 * F_CLK + 100 * DIV);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL restart_edge: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_lock();
        for (int i = 0; i < 5; i++) do_edge(P50);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL prereset_lock50: got %h want %h", obs_vec(), exp_vec());
        end
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
        end
        vsync = 1'b0;
        start_after_reset();
        do_edge(P60);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset_edge: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_lock_60();
        test_50hz_switch();
        test_jitter();
        test_random();
        test_range();
        test_timeout();
        test_reset_mid_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
